// File: rtl/ct_clint_apb_mst_pkg.sv
// ---------------------------------------------------------------------------
// ct_clint_apb_pkg
// Shared definitions for the CLINT APB initiator:
//   - apb_state_e        : 2-bit FSM encoding (IDLE/SETUP/ACCESS/RESP)
//   - CLINT_*_OFF        : register offsets of the CLINT slave
//   - TIMEOUT_CYCLES_DEF : default ACCESS-phase abort limit
//   - TIMER_W            : width of the ACCESS-phase wait counter
// ---------------------------------------------------------------------------
package ct_clint_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [31:0] CLINT_MSIP_OFF     = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_OFF = 32'h0000_4000;
  localparam logic [31:0] CLINT_SSIP_OFF     = 32'h0000_C000;
  localparam logic [31:0] CLINT_STIMECMP_OFF = 32'h0000_D000;

  localparam int TIMEOUT_CYCLES_DEF = 256;

  // Wide enough for the largest legal TIMEOUT_CYCLES (65535).
  localparam int TIMER_W = 16;

endpackage

// File: rtl/ct_clint_apb_mst_if.sv
// ---------------------------------------------------------------------------
// ct_clint_apb_mst_if
// Bundles the request channel, the response channel and the CLINT APB bus.
//   modport master : view of the initiator (accepts requests, drives APB,
//                    returns responses)
//   modport slave  : view of the surroundings (issues requests, consumes
//                    responses, answers the APB bus)
// ---------------------------------------------------------------------------
interface ct_clint_apb_mst_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // request channel
  logic                  req_vld;
  logic                  req_rdy;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_write;
  logic [1:0]            req_prot;

  // response channel
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB bus towards the CLINT
  logic                  psel_clint;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic [1:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata_clint;
  logic                  pready_clint;
  logic                  perr_clint;

  modport master (
    input  req_vld, req_addr, req_wdata, req_write, req_prot,
    output req_rdy,
    output rsp_vld, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_rdy,
    output psel_clint, penable, paddr, pwdata, pwrite, pprot,
    input  prdata_clint, pready_clint, perr_clint
  );

  modport slave (
    output req_vld, req_addr, req_wdata, req_write, req_prot,
    input  req_rdy,
    input  rsp_vld, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_rdy,
    input  psel_clint, penable, paddr, pwdata, pwrite, pprot,
    output prdata_clint, pready_clint, perr_clint
  );

endinterface

// File: rtl/ct_clint_apb_mst_timer.sv
// ---------------------------------------------------------------------------
// ct_clint_apb_mst_timer
// ACCESS-phase wait counter used to abort a transfer whose slave never
// raises pready. Only instantiated when CLINT_APB_TIMEOUT_EN is defined.
// Ports:
//   clk_i    : APB clock
//   rst_ni   : asynchronous active-low reset
//   clr_i    : restart the count (asserted in the cycle before ACCESS)
//   inc_i    : one more ACCESS cycle without pready
//   expire_o : count has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module ct_clint_apb_mst_timer
  import ct_clint_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  // Next count: clear wins, saturate at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/ct_clint_apb_mst.sv
// ---------------------------------------------------------------------------
// ct_clint_apb_mst
// APB initiator for the CLINT slave port. Takes one register access at a
// time from a valid/ready request channel, runs the APB SETUP/ACCESS
// sequence and returns read data / error on a held valid/ready response.
// All outputs come straight from flops.
// Ports:
//   forever_apbclk : APB clock
//   cpurst_b       : asynchronous active-low reset
//   bus            : ct_clint_apb_mst_if.master (request, response, APB)
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT_CYCLES (2..65535).
// Optional feature: define CLINT_APB_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES cycles without pready (rsp_err=1, rsp_timeout=1).
// Without it ACCESS waits indefinitely and rsp_timeout stays 0.
// ---------------------------------------------------------------------------
module ct_clint_apb_mst
  import ct_clint_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic                forever_apbclk,
  input logic                cpurst_b,
  ct_clint_apb_mst_if.master bus
);

  apb_state_e            state_q,       state_d;
  logic                  req_rdy_q,     req_rdy_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic                  pwrite_q,      pwrite_d;
  logic [1:0]            pprot_q,       pprot_d;
  logic                  rsp_vld_q,     rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  expire_s;

`ifdef CLINT_APB_TIMEOUT_EN
  logic tmr_clr_s;
  logic tmr_inc_s;

  // Clearing during SETUP means the count is 0 in the first ACCESS cycle.
  assign tmr_clr_s = (state_q == ST_SETUP);
  assign tmr_inc_s = (state_q == ST_ACCESS) && !bus.pready_clint;

  ct_clint_apb_mst_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (forever_apbclk),
    .rst_ni   (cpurst_b),
    .clr_i    (tmr_clr_s),
    .inc_i    (tmr_inc_s),
    .expire_o (expire_s)
  );
`else
  logic unused_tmo_s;

  assign unused_tmo_s = (TIMEOUT_CYCLES > 1);
  assign expire_s     = 1'b0;
`endif

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d       = state_q;
    req_rdy_d     = req_rdy_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    pprot_d       = pprot_q;
    rsp_vld_d     = rsp_vld_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_vld) begin
          paddr_d   = bus.req_addr;
          pwdata_d  = bus.req_wdata;
          pwrite_d  = bus.req_write;
          pprot_d   = bus.req_prot;
          req_rdy_d = 1'b0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end else begin
          req_rdy_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // A slave answer in the expiry cycle still counts as a normal completion.
        if (bus.pready_clint) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_vld_d     = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata_clint;
          rsp_err_d     = bus.perr_clint;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (expire_s) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_vld_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end

      ST_RESP: begin
        // req_rdy rises only after the response is gone, so a new request
        // can never be taken in the completing cycle.
        if (bus.rsp_rdy) begin
          rsp_vld_d     = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          req_rdy_d     = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        rsp_vld_d     = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        req_rdy_d     = 1'b1;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge forever_apbclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q       <= ST_IDLE;
      req_rdy_q     <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      pprot_q       <= 2'b00;
      rsp_vld_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_rdy_q     <= req_rdy_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      pprot_q       <= pprot_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_rdy     = req_rdy_q;
  assign bus.psel_clint  = psel_q;
  assign bus.penable     = penable_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/ct_clint_apb_mst.md
Name: ct_clint_apb_mst

Overview:
- APB initiator that drives the CLINT APB slave port (psel_clint/penable/paddr/pwdata/pwrite/pprot) from a simple valid/ready request channel.
- Returns read data and error status on a buffered valid/ready response channel.
- Sits between the CIU/debug register-access path and the CLINT.
- Handles one outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles before abort; only used with CLINT_APB_TIMEOUT_EN; legal range 2..65535.

Ports:
- forever_apbclk  in  1  APB clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- req_write  in  1  1 = write, 0 = read.
- req_prot  in  2  protection attribute.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  slave error or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel_clint  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pwrite  out  1  APB direction.
- pprot  out  2  APB protection.
- prdata_clint  in  DATA_WIDTH  APB read data.
- pready_clint  in  1  APB ready.
- perr_clint  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock, forever_apbclk. Reset cpurst_b is asynchronous and active-low.
- Reset values: all outputs 0 except req_rdy, which is 1. State is IDLE.
- Reset mid-transfer drops psel_clint/penable immediately and discards the transfer; no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: req_rdy=1.
  - On req_vld, capture addr/wdata/write/prot into the paddr/pwdata/pwrite/pprot registers and go to SETUP.
  - paddr/pwdata/pwrite/pprot then stay stable until the next accept.
- SETUP: psel_clint=1, penable=0 for exactly one cycle, then go to ACCESS.
- ACCESS: psel_clint=1, penable=1.
  - Stay while pready_clint=0.
  - On pready_clint=1:
    - rsp_rdata = write ? 0 : prdata_clint
    - rsp_err = perr_clint
    - rsp_timeout = 0
    - rsp_vld=1, go to RESP.
  - psel_clint and penable deassert in the cycle after pready is sampled.
- RESP: rsp_vld, rsp_rdata, rsp_err and rsp_timeout are held until rsp_rdy=1, then go to IDLE.
  - No new request is accepted in the same cycle the response completes.
  - rsp_vld/rdata/err/timeout clear on leaving RESP.
- req_rdy=0 in SETUP, ACCESS and RESP.
- Minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2 with pready → rsp_vld at N+3. Back-to-back throughput is one transfer per 4 cycles.
- perr_clint and prdata_clint are ignored unless penable=1 and pready_clint=1.
- Response valid and ready both high in the same cycle completes that cycle; no combinational paths from rsp_rdy or req_vld to any output.

Optional Feature:
- Macro: CLINT_APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with pready_clint=0.
  - When the counter equals TIMEOUT_CYCLES-1 and pready_clint is still 0, the transfer is aborted: psel_clint/penable drop the next cycle, rsp_rdata=0, rsp_err=1, rsp_timeout=1, go to RESP.
  - If pready_clint=1 in that same cycle, the normal completion wins.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout is tied to 0.

Decomposition:
- Package ct_clint_apb_pkg holds:
  - FSM state encoding: 2-bit, IDLE=0, SETUP=1, ACCESS=2, RESP=3.
  - CLINT offset constants: MSIP 0x0000, MTIMECMP 0x4000, SSIP 0xC000, STIMECMP 0xD000.
  - Default TIMEOUT_CYCLES.
- Sub-module ct_clint_apb_mst_timer: wait counter with clear/inc/expire; instantiated only under CLINT_APB_TIMEOUT_EN.

Test Plan:
- Write 0x0000_0001 to 0x0000 (MSIP core0), slave pready in the first ACCESS cycle → SETUP then ACCESS observed, rsp_vld at accept+3, rsp_rdata=0, rsp_err=0.
- Read 0x4000 with pready held low for 5 ACCESS cycles and prdata=0xDEAD_BEEF → psel/penable held 6 cycles, all APB outputs stable, rsp_rdata=0xDEAD_BEEF.
- Read with perr_clint=1 at pready → rsp_err=1, rsp_timeout=0; rsp_rdy held low for 3 cycles → response held and req_rdy=0 throughout.
- Deassert cpurst_b during ACCESS → psel_clint/penable go 0 asynchronously, req_rdy=1, no rsp_vld after release.
- With CLINT_APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready never asserted → abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Same stimulus with pready asserted in the 4th cycle → normal completion.
- Two back-to-back requests with rsp_rdy tied high → second req_rdy at accept+4, no overlap of psel_clint between the transfers.
